// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller.
//             Defines the multiply-sequencer state encoding and the default
//             multiply occupancy of the EX stage.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer states: RUN = normal flow, MUL = multi-cycle multiply in EX.
    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } pipe_state_t;

    // Total cycles a multiply occupies the EX stage.
    localparam int unsigned MUL_LATENCY_DEFAULT = 8;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mul_sequencer
//  Purpose  : Multi-cycle multiply sequencer. Counts down the EX occupancy of
//             a multiply and flags the stall cycles and the final cycle.
//  Ports    : clock      in  system clock, rising edge
//             reset      in  synchronous, active-high
//             ex_mul_op  in  valid multiply instruction in EX
//             mul_busy   out multiply in progress, ALU must not latch result
//             mul_last   out final multiply cycle, result valid, EX advances
//             mul_stall  out front-end stall / back-end drain request
//  Revision : 1.0  initial release
// ============================================================================
module mul_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ex_mul_op,
    output logic mul_busy,
    output logic mul_last,
    output logic mul_stall
);

    // The entry cycle (in RUN) is the first stall cycle, so the countdown is
    // loaded with the number of remaining stall cycles after it.
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MUL_LATENCY - 2);

    pipe_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (ex_mul_op) begin
                    state_d = MUL;
                    cnt_d   = c_cnt_load;
                end
            end
            MUL: begin
                // ex_mul_op is not consulted here: once started, the
                // sequence always runs to completion.
                if (cnt_zero) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- output logic (Mealy) ----------------
    always_comb begin
        mul_stall = 1'b0;
        mul_last  = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN:     mul_stall = ex_mul_op;
                MUL: begin
                    mul_stall = !cnt_zero;
                    mul_last  = cnt_zero;
                end
                default: mul_stall = 1'b0;
            endcase
        end
        mul_busy = mul_stall;
    end

endmodule : mul_sequencer
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipeline. Turns
//             load-use, multi-cycle multiply and EX redirect requests into
//             per-pipe-register hold/bubble controls, a PC hold, and two
//             saturating performance counters.
//  Ports    : clock, reset            clock / synchronous active-high reset
//             ld_use_hazard           ID reads rd of load in ID/EX
//             ex_mul_op               valid multiply in EX
//             ex_redirect             taken branch/jump resolved in EX
//             pc_hold                 IFU keeps current PC
//             if_id_hold/if_id_flush  IF/ID keep / load NOP
//             id_ex_hold/id_ex_bubble ID/EX keep / load NOP
//             ex_mem_bubble           EX/MEM loads NOP
//             mul_busy/mul_last       multiply in progress / final cycle
//             stall_cycles            cycles with pc_hold=1 (saturating)
//             flush_events            cycles with redirect honoured (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_use_hazard,
    input  logic              ex_mul_op,
    input  logic              ex_redirect,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              mul_busy,
    output logic              mul_last,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    logic w_mul_stall;
    logic w_mul_last;
    logic w_redirect_ok;
    logic w_ld_use_ok;

    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    mul_sequencer #(
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mul_sequencer (
        .clock     (clock),
        .reset     (reset),
        .ex_mul_op (ex_mul_op),
        .mul_busy  (mul_busy),
        .mul_last  (w_mul_last),
        .mul_stall (w_mul_stall)
    );

    assign mul_last = w_mul_last;

    // Priority: multiply sequence > redirect > load-use. The final multiply
    // cycle still belongs to the multiply (EX holds the mul, so no redirect can
    // resolve there); a pending load-use is picked up the cycle after.
    always_comb begin
        w_redirect_ok = 1'b0;
        w_ld_use_ok   = 1'b0;
        if (!reset && !w_mul_stall && !w_mul_last) begin
            w_redirect_ok = ex_redirect;
            w_ld_use_ok   = ld_use_hazard && !ex_redirect;
        end
    end

    // Hold and bubble/flush on one register are mutually exclusive because
    // mul_stall, redirect_ok and ld_use_ok are mutually exclusive.
    always_comb begin
        pc_hold       = w_mul_stall | w_ld_use_ok;
        if_id_hold    = w_mul_stall | w_ld_use_ok;
        if_id_flush   = w_redirect_ok;
        id_ex_hold    = w_mul_stall;
        id_ex_bubble  = w_redirect_ok | w_ld_use_ok;
        ex_mem_bubble = w_mul_stall;
    end

    // Saturating performance counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_hold && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
        if (w_redirect_ok && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Scoreboard bench for pipe_hazard_ctrl. A driver applies one
//             directed vector per cycle and queues the expected outputs; a
//             monitor samples on the falling edge and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int PERF_W = 32;

    // Flag order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
    //              id_ex_bubble, ex_mem_bubble, mul_busy, mul_last}
    localparam logic [7:0] c_idle = 8'b0000_0000;
    localparam logic [7:0] c_mul  = 8'b1101_0110;
    localparam logic [7:0] c_last = 8'b0000_0001;
    localparam logic [7:0] c_ld   = 8'b1100_1000;
    localparam logic [7:0] c_red  = 8'b0010_1000;

    typedef struct packed {
        logic [7:0]        flags;
        logic [PERF_W-1:0] stall;
        logic [PERF_W-1:0] flush;
        int                step;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ld_use_hazard = 1'b1;
    logic ex_mul_op = 1'b1;
    logic ex_redirect = 1'b1;
    logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
    logic ex_mem_bubble, mul_busy, mul_last;
    logic [PERF_W-1:0] stall_cycles, flush_events;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;
    logic [PERF_W-1:0] exp_stall = '0;
    logic [PERF_W-1:0] exp_flush = '0;

    pipe_hazard_ctrl #(
        .MUL_LATENCY (8),
        .CNT_W       (4),
        .PERF_W      (PERF_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ld_use_hazard (ld_use_hazard),
        .ex_mul_op     (ex_mul_op),
        .ex_redirect   (ex_redirect),
        .pc_hold       (pc_hold),
        .if_id_hold    (if_id_hold),
        .if_id_flush   (if_id_flush),
        .id_ex_hold    (id_ex_hold),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_bubble (ex_mem_bubble),
        .mul_busy      (mul_busy),
        .mul_last      (mul_last),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    always #5 clock = ~clock;

    // One cycle of stimulus plus its hand-computed expected flags. Counter
    // expectations are the sums of earlier expected pc_hold / if_id_flush.
    task automatic drive(input logic rst, input logic ld, input logic mul,
                         input logic red, input logic [7:0] flags);
        exp_t e;
        @(posedge clock);
        #1;
        reset         = rst;
        ld_use_hazard = ld;
        ex_mul_op     = mul;
        ex_redirect   = red;
        e.flags = flags;
        e.stall = exp_stall;
        e.flush = exp_flush;
        e.step  = step_no;
        exp_q.push_back(e);
        step_no++;
        if (rst) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (flags[7]) exp_stall = exp_stall + 1;
            if (flags[5]) exp_flush = exp_flush + 1;
        end
    endtask

    task automatic mul_seq(input int n_mul);
        for (int m = 0; m < n_mul; m++) begin
            for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, c_mul);
            drive(1'b0, 1'b0, 1'b1, 1'b0, c_last);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output vector.
    initial begin : monitor
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
                       id_ex_bubble, ex_mem_bubble, mul_busy, mul_last};
                n_checks++;
                if (act === e.flags) n_pass++;
                else $display("FAIL flags step %0d: got %b expected %b", e.step, act, e.flags);
                n_checks++;
                if (stall_cycles === e.stall) n_pass++;
                else $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.step, stall_cycles, e.stall);
                n_checks++;
                if (flush_events === e.flush) n_pass++;
                else $display("FAIL flush_events step %0d: got %0d expected %0d", e.step, flush_events, e.flush);
            end
        end
    end

    initial begin : stimulus
        int waited;
        // Reset held 3 cycles with every input high: all outputs 0.
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, c_idle);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        // Single multiply: 7 stall cycles then mul_last.
        mul_seq(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        // Load-use pulse.
        drive(1'b0, 1'b1, 1'b0, 1'b0, c_ld);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        // Load-use with redirect: redirect wins, no stall.
        drive(1'b0, 1'b1, 1'b0, 1'b1, c_red);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        // Redirect alone.
        drive(1'b0, 1'b0, 1'b0, 1'b1, c_red);

        // Back-to-back multiplies, no idle gap.
        mul_seq(2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        // Multiply with load-use on entry -> hold not bubble; mul input drops
        // and redirect/load-use toggle during MUL and are ignored; load-use
        // is honoured right after mul_last.
        drive(1'b0, 1'b1, 1'b1, 1'b0, c_mul);
        for (int i = 0; i < 6; i++)
            drive(1'b0, 1'(i % 2), 1'b0, 1'b1, c_mul);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_last);
        drive(1'b0, 1'b1, 1'b0, 1'b0, c_ld);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        // Reset at multiply cycle 4, then a fresh 8-cycle multiply.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, c_mul);
        drive(1'b1, 1'b0, 1'b1, 1'b0, c_idle);
        mul_seq(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);
        drive(1'b0, 1'b0, 1'b0, 1'b0, c_idle);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clock);
            waited++;
        end
        @(posedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
